// File: rtl/lt100_dma_if.sv
`default_nettype none
// ============================================================================
// Module   : lt100_dma_if
// Brief    : LT100 common-bus initiator/target signal bundle.
// Revision : 1.0
// ============================================================================
interface lt100_dma_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    m_enable;
    logic                    m_wr_en;
    logic [ADDR_WIDTH-1:0]   m_addr;
    logic [DATA_WIDTH-1:0]   m_o_data;
    logic [DATA_WIDTH/8-1:0] m_be;
    logic                    m_ready;
    logic [DATA_WIDTH-1:0]   m_i_data;
    logic                    m_bus_err;

    modport master (
        output m_enable, m_wr_en, m_addr, m_o_data, m_be,
        input  m_ready, m_i_data, m_bus_err
    );

    modport slave (
        input  m_enable, m_wr_en, m_addr, m_o_data, m_be,
        output m_ready, m_i_data, m_bus_err
    );
endinterface
`default_nettype wire

// File: rtl/lt100_dma.sv
`default_nettype none
// ============================================================================
// Module   : lt100_dma
// Brief    : Single-channel word-copy DMA initiator for the LT100 common bus.
// Revision : 1.0
// ============================================================================
module lt100_dma #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  start,
    input  wire logic                  abort,
    input  wire logic [ADDR_WIDTH-1:0] src_addr,
    input  wire logic [ADDR_WIDTH-1:0] dst_addr,
    input  wire logic [LEN_WIDTH-1:0]  len_words,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [LEN_WIDTH-1:0]       words_left,
    lt100_dma_if.master                bus
);

    localparam int                      c_bytes   = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0]   c_step    = ADDR_WIDTH'(c_bytes);
    localparam logic [c_bytes-1:0]      c_be_all  = '1;
    localparam logic [LEN_WIDTH-1:0]    c_len_one = LEN_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD_REQ = 3'd1,
        S_RD_GAP = 3'd2,
        S_WR_REQ = 3'd3,
        S_WR_GAP = 3'd4,
        S_FIN    = 3'd5
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_src_ptr;
    logic [ADDR_WIDTH-1:0] r_dst_ptr;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_abort_pend;
    logic                  r_fail;
    logic                  w_stop;

    // An abort arriving in the very cycle the write gap closes still counts.
    assign w_stop = r_fail || (words_left == '0) || r_abort_pend || abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_src_ptr    <= '0;
            r_dst_ptr    <= '0;
            r_data       <= '0;
            r_abort_pend <= 1'b0;
            r_fail       <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            words_left   <= '0;
            bus.m_enable <= 1'b0;
            bus.m_wr_en  <= 1'b0;
            bus.m_addr   <= '0;
            bus.m_o_data <= '0;
            bus.m_be     <= '0;
        end else begin
            done <= 1'b0;
            if ((r_state != S_IDLE) && abort) begin
                r_abort_pend <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_src_ptr    <= src_addr;
                        r_dst_ptr    <= dst_addr;
                        words_left   <= len_words;
                        err          <= 1'b0;
                        busy         <= 1'b1;
                        r_abort_pend <= 1'b0;
                        r_fail       <= 1'b0;
                        if (len_words == '0) begin
                            r_state <= S_FIN;
                        end else begin
                            bus.m_enable <= 1'b1;
                            bus.m_wr_en  <= 1'b0;
                            bus.m_addr   <= src_addr;
                            bus.m_be     <= c_be_all;
                            r_state      <= S_RD_REQ;
                        end
                    end
                end

                S_RD_REQ: begin
                    if (bus.m_ready) begin
                        r_data       <= bus.m_i_data;
                        bus.m_enable <= 1'b0;
                        bus.m_be     <= '0;
                        if (bus.m_bus_err) begin
                            err    <= 1'b1;
                            r_fail <= 1'b1;
                        end
                        r_state <= S_RD_GAP;
                    end
                end

                S_RD_GAP: begin
                    if (!bus.m_ready) begin
                        if (r_fail) begin
                            r_state <= S_FIN;
                        end else begin
                            bus.m_enable <= 1'b1;
                            bus.m_wr_en  <= 1'b1;
                            bus.m_addr   <= r_dst_ptr;
                            bus.m_o_data <= r_data;
                            bus.m_be     <= c_be_all;
                            r_state      <= S_WR_REQ;
                        end
                    end
                end

                S_WR_REQ: begin
                    if (bus.m_ready) begin
                        bus.m_enable <= 1'b0;
                        bus.m_wr_en  <= 1'b0;
                        bus.m_be     <= '0;
                        if (bus.m_bus_err) begin
                            // Count and pointers stay at the failing word.
                            err    <= 1'b1;
                            r_fail <= 1'b1;
                        end else begin
                            r_src_ptr  <= r_src_ptr + c_step;
                            r_dst_ptr  <= r_dst_ptr + c_step;
                            words_left <= words_left - c_len_one;
                        end
                        r_state <= S_WR_GAP;
                    end
                end

                S_WR_GAP: begin
                    if (!bus.m_ready) begin
                        if (w_stop) begin
                            r_state <= S_FIN;
                        end else begin
                            bus.m_enable <= 1'b1;
                            bus.m_wr_en  <= 1'b0;
                            bus.m_addr   <= r_src_ptr;
                            bus.m_be     <= c_be_all;
                            r_state      <= S_RD_REQ;
                        end
                    end
                end

                S_FIN: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lt100_dma.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_lt100_dma
// Brief    : Directed self-checking bench for lt100_dma with a bus responder.
// Revision : 1.0
// ============================================================================
module tb_lt100_dma;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 16;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          start     = 1'b0;
    logic          abort     = 1'b0;
    logic [AW-1:0] src_addr  = '0;
    logic [AW-1:0] dst_addr  = '0;
    logic [LW-1:0] len_words = '0;
    logic          busy;
    logic          done;
    logic          err;
    logic [LW-1:0] words_left;

    lt100_dma_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    lt100_dma #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .len_words  (len_words),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .words_left (words_left),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Responder: raises ready lat cycles after enable, holds it until enable drops.
    int lat        = 2;
    int err_target = 0;
    int rd_cnt     = 0;
    int resp_cnt   = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.m_ready   <= 1'b0;
            bus.m_bus_err <= 1'b0;
            bus.m_i_data  <= '0;
            resp_cnt      <= 0;
        end else if (!bus.m_enable) begin
            bus.m_ready   <= 1'b0;
            bus.m_bus_err <= 1'b0;
            resp_cnt      <= 0;
        end else if (!bus.m_ready) begin
            if (resp_cnt + 1 >= lat) begin
                bus.m_ready <= 1'b1;
                resp_cnt    <= 0;
                if (!bus.m_wr_en) begin
                    bus.m_i_data  <= mem_word(bus.m_addr);
                    bus.m_bus_err <= (rd_cnt + 1 == err_target);
                    rd_cnt        <= rd_cnt + 1;
                end else begin
                    bus.m_bus_err <= 1'b0;
                end
            end else begin
                resp_cnt <= resp_cnt + 1;
            end
        end
    end

    logic [31:0] log_addr [0:127];
    logic [31:0] log_data [0:127];
    logic        log_wr   [0:127];
    int          log_n     = 0;
    int          gap_viol  = 0;
    int          done_cnt  = 0;
    int          en_cycles = 0;
    logic        prev_hs   = 1'b0;

    always @(posedge clk) begin
        if (bus.m_enable) en_cycles <= en_cycles + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (prev_hs && bus.m_enable) gap_viol <= gap_viol + 1;
        prev_hs <= bus.m_enable && bus.m_ready;
        if (bus.m_enable && bus.m_ready && log_n < 128) begin
            log_addr[log_n] <= bus.m_addr;
            log_wr[log_n]   <= bus.m_wr_en;
            log_data[log_n] <= bus.m_wr_en ? bus.m_o_data : bus.m_i_data;
            log_n           <= log_n + 1;
        end
    end

    task automatic pulse_start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
        @(negedge clk);
        src_addr  = s;
        dst_addr  = d;
        len_words = n;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        ok = (done === 1'b1);
    endtask

    task automatic count_rw(input int base, output int rd, output int wr);
        rd = 0;
        wr = 0;
        for (int i = base; i < log_n; i++) begin
            if (log_wr[i]) wr++;
            else           rd++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, err} !== 3'b000) begin
            failures++; $display("FAIL reset_flags: busy/done/err=%b expected 000", {busy, done, err});
        end
        checks++;
        if (words_left !== 16'h0) begin
            failures++; $display("FAIL reset_words_left: got %h expected 0000", words_left);
        end
        checks++;
        if (bus.m_enable !== 1'b0 || bus.m_be !== 4'h0 || bus.m_addr !== 32'h0 || bus.m_wr_en !== 1'b0) begin
            failures++; $display("FAIL reset_bus: en=%b be=%h addr=%h wr=%b expected all 0",
                                 bus.m_enable, bus.m_be, bus.m_addr, bus.m_wr_en);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || bus.m_enable !== 1'b0) begin
            failures++; $display("FAIL reset_release_idle: busy=%b en=%b expected 0 0", busy, bus.m_enable);
        end
    endtask

    task automatic test_copy4;
        int  base, db, gb;
        bit  ok;
        base = log_n; db = done_cnt; gb = gap_viol; lat = 2;
        pulse_start(32'h100, 32'h200, 16'd4);
        wait_done(300, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL copy4_done: done=%b expected 1 within budget", done);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || words_left !== 16'd0) begin
            failures++; $display("FAIL copy4_status: done=%b busy=%b err=%b left=%0d expected 0 0 0 0",
                                 done, busy, err, words_left);
        end
        checks++;
        if (log_n - base !== 8) begin
            failures++; $display("FAIL copy4_txn_count: got %0d expected 8", log_n - base);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (log_wr[base+2*i] !== 1'b0 || log_addr[base+2*i] !== 32'h100 + 32'(4*i) ||
                log_data[base+2*i] !== mem_word(32'h100 + 32'(4*i))) begin
                failures++; $display("FAIL copy4_read%0d: wr=%b addr=%h data=%h expected 0 %h %h", i,
                                     log_wr[base+2*i], log_addr[base+2*i], log_data[base+2*i],
                                     32'h100 + 32'(4*i), mem_word(32'h100 + 32'(4*i)));
            end
            checks++;
            if (log_wr[base+2*i+1] !== 1'b1 || log_addr[base+2*i+1] !== 32'h200 + 32'(4*i) ||
                log_data[base+2*i+1] !== mem_word(32'h100 + 32'(4*i))) begin
                failures++; $display("FAIL copy4_write%0d: wr=%b addr=%h data=%h expected 1 %h %h", i,
                                     log_wr[base+2*i+1], log_addr[base+2*i+1], log_data[base+2*i+1],
                                     32'h200 + 32'(4*i), mem_word(32'h100 + 32'(4*i)));
            end
        end
        checks++;
        if (gap_viol != gb) begin
            failures++; $display("FAIL copy4_gap: back-to-back enables=%0d expected 0", gap_viol - gb);
        end
        checks++;
        if (done_cnt - db != 1) begin
            failures++; $display("FAIL copy4_done_pulses: got %0d expected 1", done_cnt - db);
        end
    endtask

    task automatic test_zero_len;
        int eb;
        eb = en_cycles;
        pulse_start(32'h180, 32'h280, 16'd0);
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL zero_len_cycle1: done=%b busy=%b expected 0 1", done, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || words_left !== 16'd0) begin
            failures++; $display("FAIL zero_len_cycle2: done=%b busy=%b left=%0d expected 1 0 0",
                                 done, busy, words_left);
        end
        @(negedge clk);
        checks++;
        if (en_cycles != eb || done !== 1'b0) begin
            failures++; $display("FAIL zero_len_no_bus: enable cycles=%0d done=%b expected 0 0",
                                 en_cycles - eb, done);
        end
    endtask

    task automatic test_bus_err;
        int base, rd, wr;
        bit ok;
        base = log_n; lat = 2; err_target = rd_cnt + 2;
        pulse_start(32'h1000, 32'h2000, 16'd3);
        wait_done(300, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL buserr_done: done=%b expected 1 within budget", done);
        end
        count_rw(base, rd, wr);
        checks++;
        if (rd != 2 || wr != 1) begin
            failures++; $display("FAIL buserr_txns: reads=%0d writes=%0d expected 2 1", rd, wr);
        end
        checks++;
        if (err !== 1'b1 || words_left !== 16'd2) begin
            failures++; $display("FAIL buserr_status: err=%b left=%0d expected 1 2", err, words_left);
        end
        err_target = 0;
        @(negedge clk);
        pulse_start(32'h1100, 32'h2100, 16'd1);
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL buserr_clear: err=%b busy=%b expected 0 1", err, busy);
        end
        wait_done(300, ok);
        checks++;
        if (!ok || err !== 1'b0 || words_left !== 16'd0) begin
            failures++; $display("FAIL buserr_recover: done=%b err=%b left=%0d expected 1 0 0",
                                 done, err, words_left);
        end
    endtask

    task automatic test_abort;
        int base, rd, wr, n;
        bit ok;
        base = log_n; lat = 2; n = 0;
        pulse_start(32'h300, 32'h400, 16'd5);
        while (!(bus.m_enable === 1'b1 && bus.m_wr_en === 1'b0 && bus.m_addr === 32'h304) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 100) begin
            failures++; $display("FAIL abort_2nd_read_seen: addr=%h expected 00000304", bus.m_addr);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_done(300, ok);
        count_rw(base, rd, wr);
        checks++;
        if (!ok || rd != 2 || wr != 2) begin
            failures++; $display("FAIL abort_txns: done=%b reads=%0d writes=%0d expected 1 2 2", done, rd, wr);
        end
        checks++;
        if (words_left !== 16'd3 || err !== 1'b0 || log_addr[log_n-1] !== 32'h404) begin
            failures++; $display("FAIL abort_status: left=%0d err=%b last=%h expected 3 0 00000404",
                                 words_left, err, log_addr[log_n-1]);
        end
    endtask

    task automatic test_stall;
        int base, n;
        bit ok;
        base = log_n; lat = 11; n = 0;
        pulse_start(32'h500, 32'h600, 16'd2);
        while (!(bus.m_enable === 1'b1 && bus.m_wr_en === 1'b1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (bus.m_addr !== 32'h600 || bus.m_wr_en !== 1'b1 || bus.m_be !== 4'hF ||
                bus.m_o_data !== mem_word(32'h500) || bus.m_enable !== 1'b1) begin
                failures++; $display("FAIL stall_hold%0d: addr=%h wr=%b be=%h data=%h en=%b expected 00000600 1 f %h 1",
                                     k, bus.m_addr, bus.m_wr_en, bus.m_be, bus.m_o_data, bus.m_enable,
                                     mem_word(32'h500));
            end
            @(negedge clk);
            if (k == 3) begin
                src_addr = 32'hAAAA_0000; dst_addr = 32'hBBBB_0000; len_words = 16'd7; start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        wait_done(400, ok);
        lat = 2;
        checks++;
        if (!ok || log_n - base != 4 || words_left !== 16'd0) begin
            failures++; $display("FAIL stall_done: done=%b txns=%0d left=%0d expected 1 4 0",
                                 done, log_n - base, words_left);
        end
        checks++;
        if (log_addr[base] !== 32'h500 || log_addr[base+1] !== 32'h600 ||
            log_addr[base+2] !== 32'h504 || log_addr[base+3] !== 32'h604) begin
            failures++; $display("FAIL stall_start_ignored: addrs=%h %h %h %h expected 500 600 504 604",
                                 log_addr[base], log_addr[base+1], log_addr[base+2], log_addr[base+3]);
        end
    endtask

    task automatic test_reset_mid_and_wrap;
        int base, n;
        bit ok;
        lat = 2; n = 0;
        pulse_start(32'h700, 32'h800, 16'd3);
        while (!(bus.m_enable === 1'b1 && bus.m_wr_en === 1'b1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.m_enable !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL async_reset: en=%b busy=%b done=%b expected 0 0 0",
                                 bus.m_enable, busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        base = log_n;
        pulse_start(32'hFFFF_FFFC, 32'h900, 16'd1);
        wait_done(300, ok);
        checks++;
        if (!ok || log_n - base != 2 || err !== 1'b0) begin
            failures++; $display("FAIL wrap_done: done=%b txns=%0d err=%b expected 1 2 0", done, log_n - base, err);
        end
        checks++;
        if (log_addr[base] !== 32'hFFFF_FFFC || log_addr[base+1] !== 32'h900 ||
            log_data[base+1] !== 32'h5A5A_FFFC) begin
            failures++; $display("FAIL wrap_txns: rd=%h wr=%h data=%h expected fffffffc 00000900 5a5afffc",
                                 log_addr[base], log_addr[base+1], log_data[base+1]);
        end
        checks++;
        if (dut.r_src_ptr !== 32'h0000_0000) begin
            failures++; $display("FAIL wrap_src_ptr: got %h expected 00000000", dut.r_src_ptr);
        end
    endtask

    initial begin
        test_reset();
        test_copy4();
        test_zero_len();
        test_bus_err();
        test_abort();
        test_stall();
        test_reset_mid_and_wrap();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
